// File: rtl/led_shift_sequencer.sv
// led_shift_sequencer: synchronises the two direction keys, arbitrates them
// into an IDLE/SHIFT_L/SHIFT_R state that enables the tick counter, and moves
// a single lit LED across the bar on every counter tick while counting steps.
module led_shift_sequencer #(
    parameter int NUM_LEDS = 10,
    parameter bit WRAP     = 1'b1,
    parameter int STEP_MAX = 999999
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                key_left_ni,
    input  logic                key_right_ni,
    input  logic                tick_i,
    output logic                enable_o,
    output logic [1:0]          dir_o,
    output logic [NUM_LEDS-1:0] led_o,
    output logic [3:0]          pos_o,
    output logic                at_end_o,
    output logic [19:0]         step_count_o
);

    localparam logic [3:0]          POS_LAST  = 4'(NUM_LEDS - 1);
    localparam logic [19:0]         STEP_LAST = 20'(STEP_MAX);
    localparam logic [NUM_LEDS-1:0] LED_ONE   = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    // Encoding doubles as the dir_o code: 00 idle, 01 left, 10 right.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SHIFT_L = 2'b01,
        SHIFT_R = 2'b10
    } state_t;

    logic                key_l_meta_q, key_l_meta_d;
    logic                key_r_meta_q, key_r_meta_d;
    logic                press_l_q, press_l_d;
    logic                press_r_q, press_r_d;
    state_t              state_q, state_d;
    logic                enable_q, enable_d;
    logic [1:0]          dir_q, dir_d;
    logic [3:0]          pos_q, pos_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [19:0]         step_q, step_d;
    logic                moved;

    // Next-state logic for synchronisers, direction FSM, position and step count.
    always_comb begin
        key_l_meta_d = ~key_left_ni;
        key_r_meta_d = ~key_right_ni;
        press_l_d    = key_l_meta_q;
        press_r_d    = key_r_meta_q;

        // Both keys held cancels out: no motion and no counter enable.
        unique case ({press_l_q, press_r_q})
            2'b10:   state_d = SHIFT_L;
            2'b01:   state_d = SHIFT_R;
            default: state_d = IDLE;
        endcase

        enable_d = (state_d != IDLE);
        unique case (state_d)
            SHIFT_L: dir_d = 2'b01;
            SHIFT_R: dir_d = 2'b10;
            default: dir_d = 2'b00;
        endcase

        // The shift uses the current state, so a tick on the edge where the
        // state leaves SHIFT still moves in the old direction.
        pos_d = pos_q;
        moved = 1'b0;
        if (tick_i) begin
            unique case (state_q)
                SHIFT_L: begin
                    if (pos_q == POS_LAST) begin
                        if (WRAP) begin
                            pos_d = 4'd0;
                            moved = 1'b1;
                        end
                    end else begin
                        pos_d = pos_q + 4'd1;
                        moved = 1'b1;
                    end
                end
                SHIFT_R: begin
                    if (pos_q == 4'd0) begin
                        if (WRAP) begin
                            pos_d = POS_LAST;
                            moved = 1'b1;
                        end
                    end else begin
                        pos_d = pos_q - 4'd1;
                        moved = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        led_d = LED_ONE << pos_d;

        step_d = step_q;
        if (moved) begin
            step_d = (step_q == STEP_LAST) ? 20'd0 : step_q + 20'd1;
        end
    end

    // Direction FSM with registered enable/dir decode.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            dir_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            dir_q    <= dir_d;
        end
    end

    // Key synchronisers, LED position and step counter registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            key_l_meta_q <= 1'b0;
            key_r_meta_q <= 1'b0;
            press_l_q    <= 1'b0;
            press_r_q    <= 1'b0;
            pos_q        <= 4'd0;
            led_q        <= LED_ONE;
            step_q       <= 20'd0;
        end else begin
            key_l_meta_q <= key_l_meta_d;
            key_r_meta_q <= key_r_meta_d;
            press_l_q    <= press_l_d;
            press_r_q    <= press_r_d;
            pos_q        <= pos_d;
            led_q        <= led_d;
            step_q       <= step_d;
        end
    end

    assign enable_o     = enable_q;
    assign dir_o        = dir_q;
    assign led_o        = led_q;
    assign pos_o        = pos_q;
    assign at_end_o     = (pos_q == 4'd0) || (pos_q == POS_LAST);
    assign step_count_o = step_q;

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Directed bench for led_shift_sequencer. Three instances share one stimulus:
// a wrapping default build, a saturating build, and a build with a short step
// range so the step-counter wrap is reached quickly.
module tb_led_shift_sequencer;

    logic clk;
    logic rst_n;
    logic kl;
    logic kr;
    logic tick;

    logic        w_en, s_en, c_en;
    logic [1:0]  w_dir, s_dir, c_dir;
    logic [9:0]  w_led, s_led, c_led;
    logic [3:0]  w_pos, s_pos, c_pos;
    logic        w_end, s_end, c_end;
    logic [19:0] w_step, s_step, c_step;

    int checks;
    int failures;

    led_shift_sequencer #(.NUM_LEDS(10), .WRAP(1'b1), .STEP_MAX(999999)) dut_w (
        .clk_i(clk), .reset_ni(rst_n), .key_left_ni(kl), .key_right_ni(kr), .tick_i(tick),
        .enable_o(w_en), .dir_o(w_dir), .led_o(w_led), .pos_o(w_pos),
        .at_end_o(w_end), .step_count_o(w_step)
    );

    led_shift_sequencer #(.NUM_LEDS(10), .WRAP(1'b0), .STEP_MAX(999999)) dut_s (
        .clk_i(clk), .reset_ni(rst_n), .key_left_ni(kl), .key_right_ni(kr), .tick_i(tick),
        .enable_o(s_en), .dir_o(s_dir), .led_o(s_led), .pos_o(s_pos),
        .at_end_o(s_end), .step_count_o(s_step)
    );

    led_shift_sequencer #(.NUM_LEDS(10), .WRAP(1'b1), .STEP_MAX(7)) dut_c (
        .clk_i(clk), .reset_ni(rst_n), .key_left_ni(kl), .key_right_ni(kr), .tick_i(tick),
        .enable_o(c_en), .dir_o(c_dir), .led_o(c_led), .pos_o(c_pos),
        .at_end_o(c_end), .step_count_o(c_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        kl = 1'b1;
        kr = 1'b1;
        tick = 1'b0;
        step();
        step();
        checks++;
        if (w_led !== 10'h001) begin failures++; $display("FAIL reset_led got=%h exp=%h", w_led, 10'h001); end
        checks++;
        if (w_pos !== 4'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", w_pos); end
        checks++;
        if (w_step !== 20'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", w_step); end
        checks++;
        if (w_en !== 1'b0 || w_dir !== 2'b00) begin failures++; $display("FAIL reset_en_dir got=%b/%b exp=0/00", w_en, w_dir); end
        checks++;
        if (w_end !== 1'b1) begin failures++; $display("FAIL reset_at_end got=%b exp=1", w_end); end
        rst_n = 1'b1;
        step();
        checks++;
        if (w_led !== 10'h001 || w_pos !== 4'd0 || w_en !== 1'b0 || w_dir !== 2'b00)
        begin failures++; $display("FAIL post_reset got led=%h pos=%0d en=%b dir=%b exp led=001 pos=0 en=0 dir=00", w_led, w_pos, w_en, w_dir); end
    endtask

    task automatic test_left();
        kl = 1'b0;
        step();
        checks++;
        if (w_en !== 1'b0) begin failures++; $display("FAIL left_lat_e1 got=%b exp=0", w_en); end
        step();
        checks++;
        if (w_en !== 1'b0) begin failures++; $display("FAIL left_lat_e2 got=%b exp=0", w_en); end
        step();
        checks++;
        if (w_en !== 1'b1 || w_dir !== 2'b01) begin failures++; $display("FAIL left_lat_e3 got=%b/%b exp=1/01", w_en, w_dir); end
        for (int n = 1; n <= 3; n++) begin
            pulse_tick();
            checks++;
            if (w_pos !== 4'(n)) begin failures++; $display("FAIL left_pos got=%0d exp=%0d", w_pos, n); end
            step();
            step();
            step();
        end
        checks++;
        if (w_led !== 10'h008) begin failures++; $display("FAIL left_led got=%h exp=008", w_led); end
        checks++;
        if (w_step !== 20'd3) begin failures++; $display("FAIL left_step got=%0d exp=3", w_step); end
    endtask

    // Continue left to pos 9; the short-range counter wraps after its 8th shift.
    task automatic test_left_to_end();
        for (int n = 4; n <= 9; n++) begin
            pulse_tick();
            checks++;
            if (w_pos !== 4'(n)) begin failures++; $display("FAIL run_pos got=%0d exp=%0d", w_pos, n); end
            checks++;
            if (c_step !== 20'(n % 8)) begin failures++; $display("FAIL step_wrap got=%0d exp=%0d", c_step, n % 8); end
            step();
        end
        checks++;
        if (w_led !== 10'h200 || w_end !== 1'b1) begin failures++; $display("FAIL end_led got=%h/%b exp=200/1", w_led, w_end); end
    endtask

    task automatic test_saturate_and_left_wrap();
        pulse_tick();
        checks++;
        if (s_pos !== 4'd9 || s_end !== 1'b1 || s_step !== 20'd9)
        begin failures++; $display("FAIL sat_1 got pos=%0d end=%b step=%0d exp pos=9 end=1 step=9", s_pos, s_end, s_step); end
        checks++;
        if (w_pos !== 4'd0 || w_led !== 10'h001 || w_step !== 20'd10)
        begin failures++; $display("FAIL wrap_left got pos=%0d led=%h step=%0d exp pos=0 led=001 step=10", w_pos, w_led, w_step); end
        step();
        pulse_tick();
        checks++;
        if (s_pos !== 4'd9 || s_step !== 20'd9) begin failures++; $display("FAIL sat_2 got pos=%0d step=%0d exp pos=9 step=9", s_pos, s_step); end
        checks++;
        if (w_pos !== 4'd1) begin failures++; $display("FAIL left_after_wrap got=%0d exp=1", w_pos); end
    endtask

    // Left -> right swap goes straight from 01 to 10 with no idle cycle.
    task automatic test_right_wrap();
        kl = 1'b1;
        kr = 1'b0;
        step();
        checks++;
        if (w_dir !== 2'b01 || w_en !== 1'b1) begin failures++; $display("FAIL swap_e1 got=%b/%b exp=01/1", w_dir, w_en); end
        step();
        checks++;
        if (w_dir !== 2'b01 || w_en !== 1'b1) begin failures++; $display("FAIL swap_e2 got=%b/%b exp=01/1", w_dir, w_en); end
        step();
        checks++;
        if (w_dir !== 2'b10 || w_en !== 1'b1) begin failures++; $display("FAIL swap_e3 got=%b/%b exp=10/1", w_dir, w_en); end
        pulse_tick();
        checks++;
        if (w_pos !== 4'd0) begin failures++; $display("FAIL right_pos got=%0d exp=0", w_pos); end
        step();
        pulse_tick();
        checks++;
        if (w_pos !== 4'd9 || w_led !== 10'h200 || w_step !== 20'd13)
        begin failures++; $display("FAIL wrap_right got pos=%0d led=%h step=%0d exp pos=9 led=200 step=13", w_pos, w_led, w_step); end
        checks++;
        if (s_pos !== 4'd7) begin failures++; $display("FAIL sat_right got=%0d exp=7", s_pos); end
    endtask

    task automatic test_arbitration();
        kl = 1'b0;
        kr = 1'b0;
        step();
        step();
        step();
        checks++;
        if (w_en !== 1'b0 || w_dir !== 2'b00) begin failures++; $display("FAIL both_en_dir got=%b/%b exp=0/00", w_en, w_dir); end
        for (int n = 0; n < 5; n++) begin
            pulse_tick();
            step();
        end
        checks++;
        if (w_pos !== 4'd9 || w_step !== 20'd13) begin failures++; $display("FAIL both_hold got pos=%0d step=%0d exp pos=9 step=13", w_pos, w_step); end
        kl = 1'b1;
        kr = 1'b1;
        step();
        step();
        step();
        pulse_tick();
        checks++;
        if (w_pos !== 4'd9 || w_step !== 20'd13 || w_en !== 1'b0 || w_dir !== 2'b00)
        begin failures++; $display("FAIL idle_tick got pos=%0d step=%0d en=%b dir=%b exp pos=9 step=13 en=0 dir=00", w_pos, w_step, w_en, w_dir); end
    endtask

    task automatic test_release_edge_tick();
        kr = 1'b0;
        step();
        step();
        step();
        checks++;
        if (w_en !== 1'b1 || w_dir !== 2'b10) begin failures++; $display("FAIL rel_setup got=%b/%b exp=1/10", w_en, w_dir); end
        kr = 1'b1;
        step();
        step();
        pulse_tick();
        checks++;
        if (w_pos !== 4'd8 || w_step !== 20'd14) begin failures++; $display("FAIL rel_edge_tick got pos=%0d step=%0d exp pos=8 step=14", w_pos, w_step); end
        checks++;
        if (w_en !== 1'b0 || w_dir !== 2'b00) begin failures++; $display("FAIL rel_idle got=%b/%b exp=0/00", w_en, w_dir); end
        pulse_tick();
        checks++;
        if (w_pos !== 4'd8) begin failures++; $display("FAIL rel_after got=%0d exp=8", w_pos); end
    endtask

    task automatic test_reset_mid();
        kl = 1'b0;
        step();
        step();
        step();
        pulse_tick();
        checks++;
        if (w_pos !== 4'd9 || w_step !== 20'd15) begin failures++; $display("FAIL mid_setup got pos=%0d step=%0d exp pos=9 step=15", w_pos, w_step); end
        rst_n = 1'b0;
        #2;
        checks++;
        if (w_led !== 10'h001 || w_pos !== 4'd0 || w_step !== 20'd0 || w_en !== 1'b0 || w_dir !== 2'b00 || w_end !== 1'b1)
        begin failures++; $display("FAIL mid_reset_async got led=%h pos=%0d step=%0d en=%b dir=%b exp led=001 pos=0 step=0 en=0 dir=00", w_led, w_pos, w_step, w_en, w_dir); end
        kl = 1'b1;
        step();
        step();
        step();
        checks++;
        if (w_led !== 10'h001 || w_step !== 20'd0 || w_en !== 1'b0) begin failures++; $display("FAIL mid_reset_held got led=%h step=%0d en=%b exp 001/0/0", w_led, w_step, w_en); end
        rst_n = 1'b1;
        step();
        step();
        step();
        checks++;
        if (w_led !== 10'h001 || w_pos !== 4'd0 || w_step !== 20'd0 || w_en !== 1'b0 || w_dir !== 2'b00)
        begin failures++; $display("FAIL mid_reset_release got led=%h pos=%0d step=%0d en=%b dir=%b exp 001/0/0/0/00", w_led, w_pos, w_step, w_en, w_dir); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        kl       = 1'b1;
        kr       = 1'b1;
        tick     = 1'b0;
        #1;
        test_reset();
        test_left();
        test_left_to_end();
        test_saturate_and_left_wrap();
        test_right_wrap();
        test_arbitration();
        test_release_edge_tick();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
